uart_tx: RTL and testbench

UART serializer that sits directly downstream of the TX interface stage. It consumes a one-cycle start strobe plus a data word, and shifts out one 8N1-style frame on the serial line: start bit, NB_DATA data bits LSB first, then a stop bit. Bit timing is derived from the shared oversampling baud tick, the same tick the UART RX uses. A level "ready" output tells the interface stage when a new word may be pushed.

---
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle between the TX interface stage and the
// uart_tx serializer. The interface stage is the master; the serializer is
// the slave.
interface uart_tx_if #(
  parameter int unsigned NB_DATA = 8
);
  logic               i_tick;
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_done_tx;

  modport master (
    output i_tick,
    output i_tx_start,
    output i_data,
    input  o_tx,
    input  o_done_tx
  );

  modport slave (
    input  i_tick,
    input  i_tx_start,
    input  i_data,
    output o_tx,
    output o_done_tx
  );
endinterface

// File: rtl/uart_tx.sv
// UART serializer: start bit, NB_DATA data bits LSB first, then a stop bit
// of SB_TICK baud ticks. Bit timing comes from the shared oversampling tick.
// o_done_tx is high while idle and a new word may be pushed.
module uart_tx #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned N_TICKS = 16,
  parameter int unsigned SB_TICK = 16
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_tx_if.slave bus
);

  localparam int unsigned S_MAX = (N_TICKS > SB_TICK) ? N_TICKS : SB_TICK;
  localparam int unsigned S_W   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int unsigned N_W   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [S_W-1:0] S_LAST_BIT  = S_W'(N_TICKS - 1);
  localparam logic [S_W-1:0] S_LAST_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               tx_q, tx_d;

  // Next-state, counter and shift-register logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        // A tick coincident with the accepted strobe is deliberately not counted.
        if (bus.i_tx_start) begin
          shift_d = bus.i_data;
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (bus.i_tick) begin
          if (s_q == S_LAST_BIT) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.i_tick) begin
          if (s_q == S_LAST_BIT) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.i_tick) begin
          if (s_q == S_LAST_STOP) begin
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  // Line level derived from the next state so the registered o_tx moves on
  // the same edge as the state and shift register.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // State, counters, shift register and line register; async reset abandons any frame.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.o_tx      = tx_q;
  assign bus.o_done_tx = (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a monitor decodes each frame on the line
// (sampled mid bit-cell on the falling clock) and compares it against
// expected frames queued when the start strobe is driven.
module tb_uart_tx;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tick_div   = 1;
  int   tick_phase = 0;

  // Free-running clock.
  always #5 clk = ~clk;

  uart_tx_if #(.NB_DATA(8)) bus0 ();
  uart_tx_if #(.NB_DATA(8)) bus1 ();

  uart_tx #(.NB_DATA(8), .N_TICKS(16), .SB_TICK(16)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus0)
  );

  uart_tx #(.NB_DATA(8), .N_TICKS(16), .SB_TICK(32)) dut32 (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus1)
  );

  typedef struct {
    int         ch;
    logic [9:0] bits;     // bit cell k of the frame at index k (start at 0, stop at 9)
    int         ticks;    // ticks with o_done_tx low
    int         clks;     // clocks with o_done_tx low, 0 = not checked
    int         lowclks;  // clocks with o_tx low inside the frame, 0 = not checked
    int         idle;     // idle clocks before this frame, -1 = not checked
    bit         abort;    // frame is cut short by reset
  } exp_t;

  exp_t sbq[$];
  int   n_checks      = 0;
  int   n_errors      = 0;
  int   frames_seen   = 0;
  int   frames_pushed = 0;

  bit         m_act       [2] = '{default: 1'b0};
  int         m_ticks     [2] = '{default: 0};
  int         m_clks      [2] = '{default: 0};
  int         m_low       [2] = '{default: 0};
  int         m_idle      [2] = '{default: 0};
  int         m_last_idle [2] = '{default: 0};
  logic [9:0] m_bits      [2];
  logic       m_prev_done [2] = '{default: 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic finish_frame(input int c);
    exp_t e;
    frames_seen++;
    check("sb_has_entry", sbq.size() != 0, 1'b1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    check("frame_ch", c, e.ch);
    if (e.abort) begin
      check("abort_short", m_ticks[c] < e.ticks, 1'b1);
    end else begin
      check("frame_bits", m_bits[c], e.bits);
      check("frame_ticks", m_ticks[c], e.ticks);
      if (e.clks > 0)    check("frame_clks", m_clks[c], e.clks);
      if (e.lowclks > 0) check("low_clks", m_low[c], e.lowclks);
      if (e.idle >= 0)   check("idle_gap", m_last_idle[c], e.idle);
    end
  endtask

  task automatic mon_step(input int c, input logic tx, input logic done, input logic tick);
    if (!m_act[c]) begin
      if (m_prev_done[c] === 1'b1 && done === 1'b0) begin
        m_act[c]       = 1'b1;
        m_ticks[c]     = 0;
        m_clks[c]      = 0;
        m_low[c]       = 0;
        m_bits[c]      = '0;
        m_last_idle[c] = m_idle[c];
        m_idle[c]      = 0;
      end else if (done === 1'b1) begin
        m_idle[c]++;
      end
    end
    if (m_act[c]) begin
      if (done === 1'b0) begin
        m_clks[c]++;
        if (tx === 1'b0) m_low[c]++;
        if (tick === 1'b1) begin
          if ((m_ticks[c] % 16) == 8 && (m_ticks[c] / 16) <= 9)
            m_bits[c][m_ticks[c] / 16] = tx;
          m_ticks[c]++;
        end
      end else begin
        m_act[c]  = 1'b0;
        m_idle[c] = 1;
        finish_frame(c);
      end
    end
    m_prev_done[c] = done;
  endtask

  // Frame monitor, sampling away from the active edge.
  always @(negedge clk) begin
    mon_step(0, bus0.o_tx, bus0.o_done_tx, bus0.i_tick);
    mon_step(1, bus1.o_tx, bus1.o_done_tx, bus1.i_tick);
  end

  // Shared baud tick, one pulse every tick_div clocks.
  initial begin
    bus0.i_tick = 1'b0;
    bus1.i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_phase++;
      if (tick_phase >= tick_div) tick_phase = 0;
      bus0.i_tick = (tick_phase == 0);
      bus1.i_tick = (tick_phase == 0);
    end
  end

  task automatic push_exp(input int ch, input logic [7:0] d, input int ticks, input int clks,
                          input int lowclks, input int idle, input bit abort);
    exp_t e;
    e.ch      = ch;
    e.bits    = {1'b1, d, 1'b0};
    e.ticks   = ticks;
    e.clks    = clks;
    e.lowclks = lowclks;
    e.idle    = idle;
    e.abort   = abort;
    sbq.push_back(e);
    frames_pushed++;
  endtask

  // Waits for idle with a tick due on the next edge, then pulses the strobe.
  task automatic send(input int ch, input logic [7:0] d);
    int   budget = 5000;
    logic done;
    @(posedge clk);
    #2;
    done = (ch == 0) ? bus0.o_done_tx : bus1.o_done_tx;
    while (!(done === 1'b1 && bus0.i_tick === 1'b1) && budget > 0) begin
      @(posedge clk);
      #2;
      done = (ch == 0) ? bus0.o_done_tx : bus1.o_done_tx;
      budget--;
    end
    if (budget == 0) begin
      check("send_wait_idle", done, 1'b1);
      return;
    end
    if (ch == 0) begin
      bus0.i_tx_start = 1'b1;
      bus0.i_data     = d;
    end else begin
      bus1.i_tx_start = 1'b1;
      bus1.i_data     = d;
    end
    @(posedge clk);
    #2;
    bus0.i_tx_start = 1'b0;
    bus1.i_tx_start = 1'b0;
    bus0.i_data     = 8'($urandom);
    bus1.i_data     = 8'($urandom);
  endtask

  task automatic wait_drain(input string tag, input int ch);
    int budget = 4000;
    while ((sbq.size() != 0 || m_act[ch]) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    check(tag, sbq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus0.i_tx_start = 1'b0;
    bus1.i_tx_start = 1'b0;
    bus0.i_data     = '0;
    bus1.i_data     = '0;

    // 1: reset state and idle stability
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rst_tx", bus0.o_tx, 1'b1);
    check("rst_done", bus0.o_done_tx, 1'b1);
    check("rst_tx_sb32", bus1.o_tx, 1'b1);
    check("rst_done_sb32", bus1.o_done_tx, 1'b1);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (!(bus0.o_tx === 1'b1 && bus0.o_done_tx === 1'b1 &&
            bus1.o_tx === 1'b1 && bus1.o_done_tx === 1'b1)) ok = 1'b0;
    end
    check("idle_stable", ok, 1'b1);

    // 2: single frame 0xA5, tick every clock
    tick_div = 1;
    push_exp(0, 8'hA5, 160, 160, 0, -1, 1'b0);
    send(0, 8'hA5);
    wait_drain("drain_a5", 0);

    // 3: sparse tick, 0x00: 64-clock cells, 640-clock frame, line low for 9 cells
    tick_div = 4;
    push_exp(0, 8'h00, 160, 640, 576, -1, 1'b0);
    send(0, 8'h00);
    wait_drain("drain_sparse", 0);

    // 4: strobe with new data mid-frame is ignored and queues nothing
    tick_div = 1;
    push_exp(0, 8'h3C, 160, 160, 0, -1, 1'b0);
    send(0, 8'h3C);
    repeat (39) @(posedge clk);
    #2;
    bus0.i_tx_start = 1'b1;
    bus0.i_data     = 8'hFF;
    @(posedge clk);
    #2;
    bus0.i_tx_start = 1'b0;
    wait_drain("drain_3c", 0);
    repeat (300) @(posedge clk);
    check("no_second_frame", frames_seen, frames_pushed);

    // 5: asynchronous reset during data bit 3 of 0x55, then a clean 0x81
    push_exp(0, 8'h55, 160, 0, 0, -1, 1'b1);
    send(0, 8'h55);
    repeat (70) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx", bus0.o_tx, 1'b1);
    check("async_rst_done", bus0.o_done_tx, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    wait_drain("drain_abort", 0);
    push_exp(0, 8'h81, 160, 160, 0, -1, 1'b0);
    send(0, 8'h81);
    wait_drain("drain_81", 0);

    // 6: SB_TICK=32, back-to-back 0x01 then 0x80 with one idle clock between
    push_exp(1, 8'h01, 176, 176, 0, -1, 1'b0);
    push_exp(1, 8'h80, 176, 176, 0, 1, 1'b0);
    send(1, 8'h01);
    send(1, 8'h80);
    wait_drain("drain_b2b", 1);

    repeat (20) @(posedge clk);
    check("frames_total", frames_seen, frames_pushed);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
